// File: rtl/word_demux_2out.sv
// Buffered 1-to-2 word demultiplexer.
// Each input word is steered by in_select into one of two independent FIFOs (A for 0, B for 1).
// Each output has its own valid/ready handshake, so a stalled consumer only holds up words
// aimed at it and never disturbs traffic to the other output.
module word_demux_2out #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a_word,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_b_word,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [15:0]      count_a,
    output logic [15:0]      count_b
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FillFull = CntW'(DEPTH);

    // Word storage (deliberately not reset; only pointers and fill counts are)
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];

    // FIFO A bookkeeping
    logic [PtrW-1:0] wr_ptr_a_q, wr_ptr_a_d;
    logic [PtrW-1:0] rd_ptr_a_q, rd_ptr_a_d;
    logic [CntW-1:0] fill_a_q, fill_a_d;
    logic [15:0]     count_a_q, count_a_d;

    // FIFO B bookkeeping
    logic [PtrW-1:0] wr_ptr_b_q, wr_ptr_b_d;
    logic [PtrW-1:0] rd_ptr_b_q, rd_ptr_b_d;
    logic [CntW-1:0] fill_b_q, fill_b_d;
    logic [15:0]     count_b_q, count_b_d;

    // Handshake qualifiers
    logic full_a, full_b;
    logic empty_a, empty_b;
    logic push_a, push_b;
    logic pop_a, pop_b;

    // Pointer advance with explicit wrap from the last slot back to 0
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrLast) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

    // Full/empty flags, input steering and output handshakes
    always_comb begin
        full_a  = (fill_a_q == FillFull);
        full_b  = (fill_b_q == FillFull);
        empty_a = (fill_a_q == '0);
        empty_b = (fill_b_q == '0);

        // Ready depends only on the selected FIFO's registered fill, never on in_valid, and a
        // full FIFO stays unready even if it is being popped this cycle.
        in_ready = in_select ? ~full_b : ~full_a;

        push_a = in_valid & ~in_select & ~full_a;
        push_b = in_valid &  in_select & ~full_b;

        out_a_valid = ~empty_a;
        out_b_valid = ~empty_b;
        pop_a       = out_a_valid & out_a_ready;
        pop_b       = out_b_valid & out_b_ready;

        out_a_word = empty_a ? '0 : mem_a_q[rd_ptr_a_q];
        out_b_word = empty_b ? '0 : mem_b_q[rd_ptr_b_q];

        count_a = count_a_q;
        count_b = count_b_q;
    end

    // Next-state for FIFO A pointers, fill level and delivery counter
    always_comb begin
        wr_ptr_a_d = wr_ptr_a_q;
        rd_ptr_a_d = rd_ptr_a_q;
        fill_a_d   = fill_a_q;
        count_a_d  = count_a_q;

        if (push_a) begin
            wr_ptr_a_d = ptr_inc(wr_ptr_a_q);
        end
        if (pop_a) begin
            rd_ptr_a_d = ptr_inc(rd_ptr_a_q);
            count_a_d  = count_a_q + 16'd1;
        end

        unique case ({push_a, pop_a})
            2'b10:   fill_a_d = fill_a_q + CntW'(1);
            2'b01:   fill_a_d = fill_a_q - CntW'(1);
            default: fill_a_d = fill_a_q;
        endcase
    end

    // Next-state for FIFO B pointers, fill level and delivery counter
    always_comb begin
        wr_ptr_b_d = wr_ptr_b_q;
        rd_ptr_b_d = rd_ptr_b_q;
        fill_b_d   = fill_b_q;
        count_b_d  = count_b_q;

        if (push_b) begin
            wr_ptr_b_d = ptr_inc(wr_ptr_b_q);
        end
        if (pop_b) begin
            rd_ptr_b_d = ptr_inc(rd_ptr_b_q);
            count_b_d  = count_b_q + 16'd1;
        end

        unique case ({push_b, pop_b})
            2'b10:   fill_b_d = fill_b_q + CntW'(1);
            2'b01:   fill_b_d = fill_b_q - CntW'(1);
            default: fill_b_d = fill_b_q;
        endcase
    end

    // Storage writes at the selected FIFO's write pointer
    always_ff @(posedge clk) begin
        if (push_a) begin
            mem_a_q[wr_ptr_a_q] <= in_word;
        end
        if (push_b) begin
            mem_b_q[wr_ptr_b_q] <= in_word;
        end
    end

    // Pointer, fill and counter registers; reset drops all buffered words at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_a_q <= '0;
            rd_ptr_a_q <= '0;
            fill_a_q   <= '0;
            count_a_q  <= '0;
            wr_ptr_b_q <= '0;
            rd_ptr_b_q <= '0;
            fill_b_q   <= '0;
            count_b_q  <= '0;
        end else begin
            wr_ptr_a_q <= wr_ptr_a_d;
            rd_ptr_a_q <= rd_ptr_a_d;
            fill_a_q   <= fill_a_d;
            count_a_q  <= count_a_d;
            wr_ptr_b_q <= wr_ptr_b_d;
            rd_ptr_b_q <= rd_ptr_b_d;
            fill_b_q   <= fill_b_d;
            count_b_q  <= count_b_d;
        end
    end

endmodule

// File: tb/tb_word_demux_2out.sv
// Directed bench for word_demux_2out with a per-output queue scoreboard.
module tb_word_demux_2out;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_word;
    logic             in_select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_a_word;
    logic             out_a_valid;
    logic             out_a_ready;
    logic [WIDTH-1:0] out_b_word;
    logic             out_b_valid;
    logic             out_b_ready;
    logic [15:0]      count_a;
    logic [15:0]      count_b;

    int total = 0;
    int bad   = 0;

    // Scoreboard: words expected on each output, oldest first, plus expected counters
    logic [WIDTH-1:0] qa [$];
    logic [WIDTH-1:0] qb [$];
    logic [15:0]      ca_m = 16'd0;
    logic [15:0]      cb_m = 16'd0;

    word_demux_2out #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_word    (in_word),
        .in_select  (in_select),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_a_word (out_a_word),
        .out_a_valid(out_a_valid),
        .out_a_ready(out_a_ready),
        .out_b_word (out_b_word),
        .out_b_valid(out_b_valid),
        .out_b_ready(out_b_ready),
        .count_a    (count_a),
        .count_b    (count_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, retire handshakes, advance
    task automatic cycle(input logic v, input logic sel, input logic [31:0] w,
                         input logic ra, input logic rb);
        logic acc_a, acc_b, pa, pb;
        in_valid    = v;
        in_select   = sel;
        in_word     = w;
        out_a_ready = ra;
        out_b_ready = rb;
        #1;
        chk("in_ready", {31'd0, in_ready},
            {31'd0, (sel ? qb.size() : qa.size()) < DEPTH});
        chk("a_valid", {31'd0, out_a_valid}, {31'd0, qa.size() != 0});
        chk("b_valid", {31'd0, out_b_valid}, {31'd0, qb.size() != 0});
        chk("a_word", out_a_word, (qa.size() != 0) ? qa[0] : 32'd0);
        chk("b_word", out_b_word, (qb.size() != 0) ? qb[0] : 32'd0);
        chk("count_a", {16'd0, count_a}, {16'd0, ca_m});
        chk("count_b", {16'd0, count_b}, {16'd0, cb_m});
        // Acceptance uses the pre-pop occupancy: a full FIFO never takes a word
        acc_a = v && !sel && (qa.size() < DEPTH);
        acc_b = v &&  sel && (qb.size() < DEPTH);
        pa    = ra && (qa.size() != 0);
        pb    = rb && (qb.size() != 0);
        if (pa) begin
            void'(qa.pop_front());
            ca_m = ca_m + 16'd1;
        end
        if (pb) begin
            void'(qb.pop_front());
            cb_m = cb_m + 16'd1;
        end
        if (acc_a) qa.push_back(w);
        if (acc_b) qb.push_back(w);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        in_valid    = 1'b0;
        in_select   = 1'b0;
        in_word     = '0;
        out_a_ready = 1'b0;
        out_b_ready = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;

        // Reset values
        #2;
        chk("rst_in_ready_sel0", {31'd0, in_ready}, 32'd1);
        in_select = 1'b1;
        #1;
        chk("rst_in_ready_sel1", {31'd0, in_ready}, 32'd1);
        chk("rst_a_valid", {31'd0, out_a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, out_b_valid}, 32'd0);
        chk("rst_a_word", out_a_word, 32'd0);
        chk("rst_b_word", out_b_word, 32'd0);
        chk("rst_count_a", {16'd0, count_a}, 32'd0);
        chk("rst_count_b", {16'd0, count_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Routing with both consumers ready
        cycle(1'b1, 1'b0, 32'h1111_1111, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'h3333_3333, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("route_count_a", {16'd0, count_a}, 32'd2);
        chk("route_count_b", {16'd0, count_b}, 32'd1);

        // Back-pressure on A; B keeps flowing; third A word stalls, then full-with-pop
        cycle(1'b1, 1'b0, 32'hA000_0001, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'hA000_0002, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'hB000_0001, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'hA000_0003, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'hA000_0003, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'hA000_0003, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'hA000_0003, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("bp_count_a", {16'd0, count_a}, 32'd5);
        chk("bp_count_b", {16'd0, count_b}, 32'd2);

        // Async reset while both FIFOs hold data
        cycle(1'b1, 1'b0, 32'hC000_0001, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'hC000_0002, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'hC000_0003, 1'b0, 1'b0);
        chk("pre_rst_a_valid", {31'd0, out_a_valid}, 32'd1);
        chk("pre_rst_b_valid", {31'd0, out_b_valid}, 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a_valid", {31'd0, out_a_valid}, 32'd0);
        chk("arst_b_valid", {31'd0, out_b_valid}, 32'd0);
        chk("arst_a_word", out_a_word, 32'd0);
        chk("arst_b_word", out_b_word, 32'd0);
        chk("arst_count_a", {16'd0, count_a}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        qa.delete();
        qb.delete();
        ca_m = 16'd0;
        cb_m = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // Counter wrap: 65537 pops on B
        for (int i = 0; i < 65538; i++) cycle(1'b1, 1'b1, 32'(i), 1'b1, 1'b1);
        #1;
        chk("wrap_count_b", {16'd0, count_b}, 32'd1);
        chk("wrap_count_a", {16'd0, count_a}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_demux_2out.md
# word_demux_2out

Buffered 1-to-2 word demultiplexer: the steering counterpart of the 2-input word mux. Accepts a stream of WIDTH-bit words with a per-word select bit over a valid/ready handshake and routes each word into one of two independently back-pressured output FIFOs (A for select 0, B for select 1). It sits between a single word producer and two consumers so that a stalled consumer never corrupts or reorders traffic to the other.

## Interface
- WIDTH, 32, word width in bits
- DEPTH, 2, entries per output FIFO; power of two, ≥ 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_word  input  WIDTH  word to route
- in_select  input  1  destination: 0 → A, 1 → B
- in_valid  input  1  in_word/in_select valid
- in_ready  output  1  block can accept the offered word this cycle
- out_a_word  output  WIDTH  head word of FIFO A; 0 when out_a_valid low
- out_a_valid  output  1  FIFO A non-empty
- out_a_ready  input  1  consumer A takes head this cycle
- out_b_word / out_b_valid / out_b_ready: same as A, for FIFO B
- count_a  output  16  words delivered on A (pops), wraps mod 2^16
- count_b  output  16  words delivered on B, wraps mod 2^16

## Operation
- Two FIFOs, each: DEPTH×WIDTH storage, write/read pointers of log2(DEPTH) bits plus a fill count of log2(DEPTH)+1 bits.
- in_ready = NOT full(FIFO selected by in_select); purely combinational from in_select and fill counts. in_ready must not depend on in_valid.
- Push: in_valid & in_ready → in_word written at selected FIFO's write pointer; pointer increments, wraps DEPTH-1 → 0.
- Pop: out_x_valid & out_x_ready → read pointer increments (wrap), count_x increments.
- Simultaneous push and pop on same FIFO: both occur; fill count unchanged. Allowed when FIFO is non-full. A full FIFO rejects the push even if a pop occurs that cycle (no same-cycle pass-through of freed slot).
- Simultaneous push to one FIFO and pop on the other: fully independent.
- Ordering: preserved within each output; no ordering relationship between A and B.
- A full FIFO only stalls input words selecting it; the upstream producer is responsible for not changing in_word/in_select while in_valid is high and in_ready is low (holding is required by protocol).
- out_x_word = storage[read pointer] when non-empty, else 0.
- Storage contents are not reset; pointers, fill counts, counters are.

## Timing
- Reset (rst_n low, asynchronous): fill counts 0, pointers 0, count_a = count_b = 0 → out_a_valid = out_b_valid = 0, out_a_word = out_b_word = 0, in_ready = 1 for either select.
- Reset asserted mid-operation: all buffered words discarded immediately; outputs take reset values without waiting for clk.
- Deassertion: first accept possible on the first rising edge with rst_n high.
- Latency: word accepted at edge N is visible on out_x_word with out_x_valid = 1 after edge N (i.e. during cycle N+1); minimum in-to-out latency 1 cycle.
- Throughput: 1 word/cycle per output sustained when the consumer holds ready high.
- Full: after DEPTH pushes with no pops, in_ready = 0 for that select in the following cycle; goes back to 1 the cycle after the first pop.
- Counters update on the same edge as the pop; 0xFFFF + 1 → 0x0000.

## Test plan
- Reset: rst_n low → in_ready 1, both valids 0, both words 0, counts 0; release, no traffic for 5 cycles → unchanged.
- Routing: both readies high, push 0x11111111/sel 0, 0x22222222/sel 1, 0x33333333/sel 0 on consecutive cycles → A delivers 0x11111111 then 0x33333333, B delivers 0x22222222, each one cycle after accept; count_a = 2, count_b = 1.
- Back-pressure isolation: out_a_ready low, push 3 words to A (DEPTH=2) → third stalls with in_ready 0; meanwhile a sel-1 word is accepted and delivered on B; raise out_a_ready → A delivers all 3 in order.
- Full with simultaneous pop: A full, out_a_ready high, offer sel 0 → in_ready 0 that cycle, accepted next cycle; no word lost or duplicated.
- Counter wrap: preload via 65 537 pops on B → count_b = 1, count_a = 0.
- Async reset mid-stream: both FIFOs holding data, pulse rst_n low between clock edges → valids and words 0 immediately, buffered data never appears afterwards.
